// File: rtl/tc_cascade_accumulator.sv
// Upper event accumulator cascaded after a 4-bit counter: counts TC rising edges,
// flags sticky overflow and limit hits, and serves a coherent {upper, Q} snapshot.
module tc_cascade_accumulator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 CP,
    input  logic                 SR,
    input  logic                 TC_IN,
    input  logic [3:0]           Q_IN,
    input  logic                 CLR,
    input  logic [WIDTH-1:0]     LIMIT,
    input  logic                 SNAP_REQ,
    input  logic                 SNAP_ACK,
    output logic [WIDTH-1:0]     UPPER,
    output logic                 OVF,
    output logic                 LIMIT_HIT,
    output logic                 SNAP_VALID,
    output logic [WIDTH+3:0]     SNAP_DATA
);

    localparam int unsigned SNAP_W = WIDTH + 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             tc_d;
    logic             inc;
    logic             capture;
    logic [WIDTH-1:0] upper_inc;

    // A TC held high counts once: only its rising edge is an event.
    assign inc       = TC_IN & ~tc_d;
    assign upper_inc = UPPER + WIDTH'(1);

    always_ff @(posedge CP) begin
        if (!SR) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Snapshot handshake: capture only from IDLE, release on ack; clear forces IDLE.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        if (CLR) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (SNAP_REQ) begin
                        capture    = 1'b1;
                        state_next = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (SNAP_ACK) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CP) begin
        if (!SR) begin
            tc_d       <= 1'b0;
            UPPER      <= '0;
            OVF        <= 1'b0;
            LIMIT_HIT  <= 1'b0;
            SNAP_VALID <= 1'b0;
            SNAP_DATA  <= '0;
        end else begin
            tc_d       <= TC_IN;
            SNAP_VALID <= (state_next == S_HOLD);
            if (CLR) begin
                UPPER     <= '0;
                OVF       <= 1'b0;
                LIMIT_HIT <= 1'b0;
            end else begin
                LIMIT_HIT <= inc && (upper_inc == LIMIT);
                if (inc) begin
                    UPPER <= upper_inc;
                    if (&UPPER) begin
                        OVF <= 1'b1;
                    end
                end
                // Pre-update UPPER pairs coherently with the Q_IN sampled at this edge.
                if (capture) begin
                    SNAP_DATA <= SNAP_W'({UPPER, Q_IN});
                end
            end
        end
    end

endmodule
